// File: rtl/runner_pkg.sv
// Shared types and helpers for the gravity-runner core: game state encoding,
// the lane LFSR polynomial and the lane height function.
package runner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_DEAD = 2'b10
  } state_e;

  // Galois form of x^16 + x^14 + x^13 + x^11, shifting toward bit 0
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int lane_y(input int idx, input int base, input int pitch);
    return base + idx * pitch;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Ground unless both low bits are set: one gap in four on average
  function automatic logic lfsr_ground_bit(input logic [15:0] cur);
    return ~(cur[0] & cur[1]);
  endfunction

endpackage

// File: rtl/runner_core_if.sv
// Game I/O bundle between the runner core and its renderer/score display.
// The high_score member exists only when RUNNER_HISCORE_EN is defined.
interface runner_core_if #(
  parameter int NUM_LANES = 3,
  parameter int LINE_LEN  = 640,
  parameter int HEIGHT_W  = 9,
  parameter int SCORE_W   = 16
);
  logic                          start;
  logic                          switch;
  logic [NUM_LANES*LINE_LEN-1:0] ground_o;
  logic [NUM_LANES-1:0]          lanes;
  logic [HEIGHT_W-1:0]           height;
  logic                          dir;
  logic [1:0]                    state;
  logic                          in_game;
  logic                          is_dead;
  logic                          tick;
  logic [SCORE_W-1:0]            score;
`ifdef RUNNER_HISCORE_EN
  logic [SCORE_W-1:0]            high_score;
`endif

  modport master (
`ifdef RUNNER_HISCORE_EN
    input  high_score,
`endif
    output start, switch,
    input  ground_o, lanes, height, dir, state, in_game, is_dead, tick, score
  );

  modport slave (
`ifdef RUNNER_HISCORE_EN
    output high_score,
`endif
    input  start, switch,
    output ground_o, lanes, height, dir, state, in_game, is_dead, tick, score
  );
endinterface

// File: rtl/runner_lane_gen.sv
// One scrolling ground lane: a 16-bit LFSR feeding a LINE_LEN shift register
// that moves toward bit 0 on every enabled game tick.
module lane_gen
  import runner_pkg::*;
#(
  parameter int LINE_LEN = 640
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic                shift_en,
  input  logic [15:0]         seed,
  output logic [LINE_LEN-1:0] line
);

  logic [15:0]         lfsr_q, lfsr_d;
  logic [LINE_LEN-1:0] line_q, line_d;

  // Next lane contents: reload, scroll one column, or hold
  always_comb begin
    lfsr_d = lfsr_q;
    line_d = line_q;
    if (init) begin
      lfsr_d = seed;
      line_d = {LINE_LEN{1'b1}};
    end else if (shift_en) begin
      lfsr_d = lfsr_next(lfsr_q);
      line_d = LINE_LEN'({lfsr_ground_bit(lfsr_q), line_q} >> 1);
    end else begin
      lfsr_d = lfsr_q;
      line_d = line_q;
    end
  end

  // Lane state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= seed;
      line_q <= {LINE_LEN{1'b1}};
    end else begin
      lfsr_q <= lfsr_d;
      line_q <= line_d;
    end
  end

  assign line = line_q;

endmodule

// File: rtl/runner_core.sv
// Gravity-runner game core: tick prescaler, input edge detect, game FSM,
// lane generators, player movement/collision and saturating score.
// Optional best-score tracking is built when RUNNER_HISCORE_EN is defined.
module runner_core
  import runner_pkg::*;
#(
  parameter int NUM_LANES  = 3,
  parameter int LINE_LEN   = 640,
  parameter int PROBE_COL  = 20,
  parameter int HEIGHT_W   = 9,
  parameter int LANE_BASE  = 60,
  parameter int LANE_PITCH = 120,
  parameter int TICK_DIV   = 4,
  parameter int SCORE_W    = 16,
  parameter int SEED       = 1
) (
  input logic         clk,
  input logic         reset,
  runner_core_if.slave bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [HEIGHT_W-1:0] HEIGHT_RST = HEIGHT_W'(LANE_BASE);
  localparam logic [HEIGHT_W-1:0] HEIGHT_TOP = {HEIGHT_W{1'b1}};
  localparam logic [SCORE_W-1:0]  SCORE_MAX  = {SCORE_W{1'b1}};

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          tick_q, tick_d;
  logic                          start_prev_q, start_prev_d;
  logic                          switch_prev_q, switch_prev_d;
  logic [HEIGHT_W-1:0]           height_q, height_d;
  logic                          dir_q, dir_d;
  logic                          pending_q, pending_d;
  logic [SCORE_W-1:0]            score_q, score_d, score_inc_s;
  logic [NUM_LANES*LINE_LEN-1:0] ground_s;
  logic [NUM_LANES-1:0]          lanes_s;
  logic start_edge_s, switch_edge_s, flip_req_s, grounded_s, at_limit_s;
  logic lane_init_s, lane_shift_s;
`ifdef RUNNER_HISCORE_EN
  logic [SCORE_W-1:0]            high_score_q, high_score_d;
`endif

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam logic [15:0] LANE_SEED = 16'(SEED + 2 * g + 1);
    lane_gen #(.LINE_LEN(LINE_LEN)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .init     (lane_init_s),
      .shift_en (lane_shift_s),
      .seed     (LANE_SEED),
      .line     (ground_s[g*LINE_LEN +: LINE_LEN])
    );
    assign lanes_s[g] = ground_s[g*LINE_LEN + PROBE_COL];
  end

  // Prescaler, edge detect, FSM and tick movement; all decisions use pre-tick values
  always_comb begin
    cnt_d         = (cnt_q == CNT_LAST) ? {CNT_W{1'b0}} : cnt_q + CNT_W'(1);
    tick_d        = (cnt_q == CNT_LAST);
    start_prev_d  = bus.start;
    switch_prev_d = bus.switch;
    start_edge_s  = bus.start & ~start_prev_q;
    switch_edge_s = bus.switch & ~switch_prev_q;
    flip_req_s    = pending_q | switch_edge_s;
    grounded_s    = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      grounded_s = grounded_s |
                   (lanes_s[i] & (int'(height_q) == lane_y(i, LANE_BASE, LANE_PITCH)));
    end
    at_limit_s   = dir_q ? (height_q == HEIGHT_TOP) : (height_q == {HEIGHT_W{1'b0}});
    score_inc_s  = (score_q == SCORE_MAX) ? score_q : score_q + SCORE_W'(1);
    state_d      = state_q;
    height_d     = height_q;
    dir_d        = dir_q;
    pending_d    = pending_q;
    score_d      = score_q;
    lane_init_s  = 1'b0;
    lane_shift_s = 1'b0;
`ifdef RUNNER_HISCORE_EN
    high_score_d = high_score_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_edge_s) begin
          state_d = ST_PLAY;
          score_d = {SCORE_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (tick_q) begin
          // A pending flip never survives a tick: used, dropped mid-air, or moot on death
          pending_d = 1'b0;
          if (grounded_s && flip_req_s) begin
            dir_d        = ~dir_q;
            score_d      = score_inc_s;
            lane_shift_s = 1'b1;
          end else if (grounded_s) begin
            score_d      = score_inc_s;
            lane_shift_s = 1'b1;
          end else if (at_limit_s) begin
            state_d = ST_DEAD;
`ifdef RUNNER_HISCORE_EN
            high_score_d = (score_q > high_score_q) ? score_q : high_score_q;
`endif
          end else begin
            height_d     = dir_q ? height_q + HEIGHT_W'(1) : height_q - HEIGHT_W'(1);
            score_d      = score_inc_s;
            lane_shift_s = 1'b1;
          end
        end else begin
          pending_d = flip_req_s;
        end
      end
      ST_DEAD: begin
        if (start_edge_s) begin
          state_d     = ST_IDLE;
          height_d    = HEIGHT_RST;
          dir_d       = 1'b0;
          pending_d   = 1'b0;
          score_d     = {SCORE_W{1'b0}};
          lane_init_s = 1'b1;
        end else begin
          state_d = ST_DEAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Game state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= {CNT_W{1'b0}};
      tick_q        <= 1'b0;
      start_prev_q  <= 1'b0;
      switch_prev_q <= 1'b0;
      height_q      <= HEIGHT_RST;
      dir_q         <= 1'b0;
      pending_q     <= 1'b0;
      score_q       <= {SCORE_W{1'b0}};
`ifdef RUNNER_HISCORE_EN
      high_score_q  <= {SCORE_W{1'b0}};
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tick_q        <= tick_d;
      start_prev_q  <= start_prev_d;
      switch_prev_q <= switch_prev_d;
      height_q      <= height_d;
      dir_q         <= dir_d;
      pending_q     <= pending_d;
      score_q       <= score_d;
`ifdef RUNNER_HISCORE_EN
      high_score_q  <= high_score_d;
`endif
    end
  end

  assign bus.ground_o = ground_s;
  assign bus.lanes    = lanes_s;
  assign bus.height   = height_q;
  assign bus.dir      = dir_q;
  assign bus.state    = state_q;
  assign bus.in_game  = (state_q == ST_PLAY);
  assign bus.is_dead  = (state_q == ST_DEAD);
  assign bus.tick     = tick_q;
  assign bus.score    = score_q;
`ifdef RUNNER_HISCORE_EN
  assign bus.high_score = high_score_q;
`endif

endmodule
